// File: rtl/door_access_if.sv
// ---------------------------------------------------------------------------
// door_access_if
//   Bundles the signals between the door access sequencer and its
//   surroundings: the keypad checker, the door sensor and the bolt/alarm side.
//
//   Parameter
//     FAIL_W     width of fail_cnt, clog2(MAX_FAIL+1) of the controller
//
//   Signals (directions seen from the controller, i.e. the slave modport)
//     code_ok    in   1-cycle pulse, correct code entered
//     code_err   in   1-cycle pulse, wrong code / keypad timeout
//     door_open  in   door sensor, 1 = open, already synchronous to clk
//     alarm_clr  in   1-cycle pulse, clears the sticky alarm
//     kp_en      out  keypad enable
//     lock_drv   out  bolt actuator, 1 = released
//     lockout    out  1 while the keypad is locked out
//     fail_cnt   out  consecutive failure count
//     alarm      out  sticky alarm
//     state_o    out  current sequencer state
//
//   Modports
//     master     keypad / sensor / supervisor side
//     slave      door_access_ctrl
// ---------------------------------------------------------------------------
interface door_access_if #(
  parameter int FAIL_W = 2
);
  logic              code_ok;
  logic              code_err;
  logic              door_open;
  logic              alarm_clr;
  logic              kp_en;
  logic              lock_drv;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;
  logic              alarm;
  logic [2:0]        state_o;

  modport master (
    output code_ok, code_err, door_open, alarm_clr,
    input  kp_en, lock_drv, lockout, fail_cnt, alarm, state_o
  );

  modport slave (
    input  code_ok, code_err, door_open, alarm_clr,
    output kp_en, lock_drv, lockout, fail_cnt, alarm, state_o
  );
endinterface

// File: rtl/door_access_ctrl.sv
// ---------------------------------------------------------------------------
// door_access_ctrl
//   Access sequencer behind the keypad code checker. Consumes code_ok /
//   code_err pulses, drives the bolt through unlock -> open -> relock, counts
//   consecutive failures and enforces a timed keypad lockout.
//
//   Optional feature: define DOOR_ALARM_EN to enable the sticky forced-entry /
//   door-held-open alarm. Without it alarm is tied to 0 and alarm_clr is
//   ignored.
//
//   Ports
//     clk    system clock, everything on posedge
//     rs_n   synchronous active-low reset
//     bus    door_access_if.slave (keypad pulses, door sensor, alarm clear in;
//            kp_en, lock_drv, lockout, fail_cnt, alarm, state_o out)
// ---------------------------------------------------------------------------
module door_access_ctrl #(
  parameter int MAX_FAIL     = 3,
  parameter int UNLOCK_TIME  = 10,
  parameter int RELOCK_TIME  = 4,
  parameter int LOCKOUT_TIME = 30,
  parameter int HOLD_MAX     = 50,
  parameter int TMR_W        = 8
) (
  input  logic               clk,
  input  logic               rs_n,
  door_access_if.slave       bus
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNLOCK  = 3'd1,
    S_OPEN    = 3'd2,
    S_RELOCK  = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg;
  logic [FAIL_W-1:0]   fail_reg, fail_next;
  logic [FAIL_W-1:0]   fail_inc;

  assign fail_inc = fail_reg + FAIL_W'(1);

  // Next-state and failure-count logic.
  always_comb begin
    state_next = state_reg;
    fail_next  = fail_reg;
    unique case (state_reg)
      S_IDLE: begin
        // code_err wins over a simultaneous code_ok (fail-safe).
        if (bus.code_err) begin
          fail_next = fail_inc;
          if (fail_inc == FAIL_W'(MAX_FAIL)) state_next = S_LOCKOUT;
        end else if (bus.code_ok) begin
          fail_next  = '0;
          state_next = S_UNLOCK;
        end
      end
      S_UNLOCK: begin
        // An opening door beats the unlock timeout in the same cycle.
        if (bus.door_open)                             state_next = S_OPEN;
        else if (timer_reg == TMR_W'(UNLOCK_TIME - 1)) state_next = S_IDLE;
      end
      S_OPEN: begin
        if (!bus.door_open) state_next = S_RELOCK;
      end
      S_RELOCK: begin
        if (bus.door_open)                             state_next = S_OPEN;
        else if (timer_reg == TMR_W'(RELOCK_TIME - 1)) state_next = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_reg == TMR_W'(LOCKOUT_TIME - 1)) begin
          state_next = S_IDLE;
          fail_next  = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        fail_next  = '0;
      end
    endcase
  end

  // State, shared timer and failure counter. The timer restarts on every
  // state change (including RELOCK -> OPEN) and saturates otherwise.
  always_ff @(posedge clk) begin
    if (!rs_n) begin
      state_reg <= S_IDLE;
      timer_reg <= '0;
      fail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fail_reg  <= fail_next;
      if (state_next != state_reg)  timer_reg <= '0;
      else if (timer_reg != '1)     timer_reg <= timer_reg + TMR_W'(1);
    end
  end

  // Moore outputs decoded straight from the state register.
  assign bus.kp_en    = (state_reg == S_IDLE);
  assign bus.lock_drv = (state_reg == S_UNLOCK) || (state_reg == S_OPEN);
  assign bus.lockout  = (state_reg == S_LOCKOUT);
  assign bus.fail_cnt = fail_reg;
  assign bus.state_o  = state_reg;

`ifdef DOOR_ALARM_EN
  logic alarm_reg;
  logic alarm_set;

  // Forced entry while the bolt should be shut, or door held open too long.
  assign alarm_set = (bus.door_open &&
                      ((state_reg == S_IDLE) || (state_reg == S_LOCKOUT))) ||
                     ((state_reg == S_OPEN) && (timer_reg == TMR_W'(HOLD_MAX - 1)));

  always_ff @(posedge clk) begin
    if (!rs_n)              alarm_reg <= 1'b0;
    else if (alarm_set)     alarm_reg <= 1'b1;   // set beats clear
    else if (bus.alarm_clr) alarm_reg <= 1'b0;
  end

  assign bus.alarm = alarm_reg;
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = &{1'b0, bus.alarm_clr, TMR_W'(HOLD_MAX)};
  assign bus.alarm = 1'b0;
`endif

endmodule

// File: tb/tb_door_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_door_access_ctrl
//   Directed bench for door_access_ctrl at default parameters. Inputs change
//   1 time unit after a rising edge; outputs are checked at the same point,
//   after the edge that is expected to have updated them.
//   Alarm expectations follow DOOR_ALARM_EN, compiled with the same defines.
// ---------------------------------------------------------------------------
module tb_door_access_ctrl;
  logic clk;
  logic rs_n;

  door_access_if #(.FAIL_W(2)) bus ();

  door_access_ctrl dut (
    .clk  (clk),
    .rs_n (rs_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DOOR_ALARM_EN
  localparam logic ALARM_EXP = 1'b1;
`else
  localparam logic ALARM_EXP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rs_n          = 1'b0;
    bus.code_ok   = 1'b0;
    bus.code_err  = 1'b0;
    bus.door_open = 1'b0;
    bus.alarm_clr = 1'b0;

    // ---- reset state
    step(); step();
    chk("rst_state",   8'(bus.state_o),  8'd0);
    chk("rst_kp_en",   8'(bus.kp_en),    8'd1);
    chk("rst_lock",    8'(bus.lock_drv), 8'd0);
    chk("rst_lockout", 8'(bus.lockout),  8'd0);
    chk("rst_fail",    8'(bus.fail_cnt), 8'd0);
    chk("rst_alarm",   8'(bus.alarm),    8'd0);
    rs_n = 1'b1;
    step();

    // ---- 1: unlock then timeout with the door closed
    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    chk("t1_unlock",   8'(bus.state_o),  8'd1);
    chk("t1_lock_rel", 8'(bus.lock_drv), 8'd1);
    chk("t1_kp_off",   8'(bus.kp_en),    8'd0);
    repeat (9) step();
    chk("t1_unlock_c10", 8'(bus.state_o), 8'd1);
    step();
    chk("t1_idle",     8'(bus.state_o),  8'd0);
    chk("t1_locked",   8'(bus.lock_drv), 8'd0);

    // ---- 2: open on the 3rd unlock cycle, relock, reopen during relock
    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    step(); step();
    bus.door_open = 1'b1; step();
    chk("t2_open",      8'(bus.state_o),  8'd2);
    chk("t2_open_lock", 8'(bus.lock_drv), 8'd1);
    repeat (3) step();
    chk("t2_open_hold", 8'(bus.state_o),  8'd2);
    bus.door_open = 1'b0; step();
    chk("t2_relock",    8'(bus.state_o),  8'd3);
    chk("t2_relock_lk", 8'(bus.lock_drv), 8'd0);
    repeat (3) step();
    chk("t2_relock_c4", 8'(bus.state_o),  8'd3);
    step();
    chk("t2_idle",      8'(bus.state_o),  8'd0);

    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    bus.door_open = 1'b1; step();
    bus.door_open = 1'b0; step();
    chk("t2_relock2",   8'(bus.state_o),  8'd3);
    step();
    bus.door_open = 1'b1; step();
    chk("t2_reopen",    8'(bus.state_o),  8'd2);
    bus.door_open = 1'b0; step();
    repeat (4) step();
    chk("t2_idle2",     8'(bus.state_o),  8'd0);

    // ---- 3: three failures -> lockout, pulses ignored, timed exit
    bus.code_err = 1'b1; step(); bus.code_err = 1'b0;
    chk("t3_fail1",     8'(bus.fail_cnt), 8'd1);
    chk("t3_idle1",     8'(bus.state_o),  8'd0);
    bus.code_err = 1'b1; step(); bus.code_err = 1'b0;
    chk("t3_fail2",     8'(bus.fail_cnt), 8'd2);
    bus.code_err = 1'b1; step(); bus.code_err = 1'b0;
    chk("t3_fail3",     8'(bus.fail_cnt), 8'd3);
    chk("t3_lockout_st",8'(bus.state_o),  8'd4);
    chk("t3_lockout",   8'(bus.lockout),  8'd1);
    chk("t3_kp_off",    8'(bus.kp_en),    8'd0);
    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    chk("t3_ok_ignored",8'(bus.state_o),  8'd4);
    bus.code_err = 1'b1; step(); bus.code_err = 1'b0;
    chk("t3_err_ignored",8'(bus.fail_cnt),8'd3);
    repeat (27) step();
    chk("t3_lockout_c30",8'(bus.state_o), 8'd4);
    step();
    chk("t3_exit_idle", 8'(bus.state_o),  8'd0);
    chk("t3_exit_fail", 8'(bus.fail_cnt), 8'd0);
    chk("t3_exit_kp",   8'(bus.kp_en),    8'd1);

    // ---- 4: success clears the count; simultaneous pulses count as failure
    bus.code_err = 1'b1; step(); step(); bus.code_err = 1'b0;
    chk("t4_fail2",     8'(bus.fail_cnt), 8'd2);
    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    chk("t4_fail_clr",  8'(bus.fail_cnt), 8'd0);
    chk("t4_unlock",    8'(bus.state_o),  8'd1);
    repeat (10) step();
    chk("t4_idle",      8'(bus.state_o),  8'd0);
    bus.code_ok = 1'b1; bus.code_err = 1'b1; step();
    bus.code_ok = 1'b0; bus.code_err = 1'b0;
    chk("t4_both_fail", 8'(bus.fail_cnt), 8'd1);
    chk("t4_both_idle", 8'(bus.state_o),  8'd0);

    // ---- 5: reset in LOCKOUT and in OPEN
    bus.code_err = 1'b1; step(); step(); bus.code_err = 1'b0;
    chk("t5_in_lockout",8'(bus.state_o),  8'd4);
    rs_n = 1'b0; step();
    chk("t5_lo_idle",   8'(bus.state_o),  8'd0);
    chk("t5_lo_fail",   8'(bus.fail_cnt), 8'd0);
    chk("t5_lo_lockout",8'(bus.lockout),  8'd0);
    rs_n = 1'b1; step();
    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    bus.door_open = 1'b1; step();
    chk("t5_in_open",   8'(bus.state_o),  8'd2);
    rs_n = 1'b0; step();
    chk("t5_op_idle",   8'(bus.state_o),  8'd0);
    chk("t5_op_lock",   8'(bus.lock_drv), 8'd0);
    chk("t5_op_alarm",  8'(bus.alarm),    8'd0);
    bus.door_open = 1'b0; rs_n = 1'b1; step();

    // ---- 6: forced entry in IDLE, set vs clear, door held open
    bus.door_open = 1'b1; step(); bus.door_open = 1'b0;
    chk("t6_force",     8'(bus.alarm),    8'(ALARM_EXP));
    chk("t6_force_st",  8'(bus.state_o),  8'd0);
    step();
    chk("t6_sticky",    8'(bus.alarm),    8'(ALARM_EXP));
    bus.alarm_clr = 1'b1; step(); bus.alarm_clr = 1'b0;
    chk("t6_clr",       8'(bus.alarm),    8'd0);
    bus.door_open = 1'b1; bus.alarm_clr = 1'b1; step();
    bus.door_open = 1'b0; bus.alarm_clr = 1'b0;
    chk("t6_set_wins",  8'(bus.alarm),    8'(ALARM_EXP));
    bus.alarm_clr = 1'b1; step(); bus.alarm_clr = 1'b0;
    chk("t6_clr2",      8'(bus.alarm),    8'd0);

    bus.code_ok = 1'b1; step(); bus.code_ok = 1'b0;
    bus.door_open = 1'b1; step();
    repeat (49) step();
    chk("t6_hold_49",   8'(bus.alarm),    8'd0);
    step();
    chk("t6_hold_50",   8'(bus.alarm),    8'(ALARM_EXP));
    chk("t6_hold_st",   8'(bus.state_o),  8'd2);
    bus.door_open = 1'b0; step();
    repeat (4) step();
    chk("t6_back_idle", 8'(bus.state_o),  8'd0);
    chk("t6_still_set", 8'(bus.alarm),    8'(ALARM_EXP));
    bus.alarm_clr = 1'b1; step(); bus.alarm_clr = 1'b0;
    chk("t6_final_clr", 8'(bus.alarm),    8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
